// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer in front of an
// 8-word x 8-bit signed scratch memory with one-cycle registered reads.
//
// Ports
//   clk, clr_n                 clock (rising edge), async active-low reset
//   req_x/we_x/addr_x/wdata_x  port x request (x = a, b), held until ack_x
//   ack_x                      one-cycle completion pulse for port x
//   rdata_x                    port x read data, updated only on its read ack
//   clr_req / clr_done         whole-memory clear request / issue pulse
//   mem_clr, mem_rw,
//   mem_address, mem_data_in   registered memory control lines
//   mem_data_out               memory read data (one cycle after address)
//   busy                       high whenever the sequencer is not IDLE
//
// Optional build macro MEM_ARB_ADDR_CHECK_EN: requests with addr >= DEPTH
// are acknowledged with err_x instead of touching the memory.
module mem_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     req_a,
  input  logic                     we_a,
  input  logic [ADDR_W-1:0]        addr_a,
  input  logic signed [DATA_W-1:0] wdata_a,
  output logic                     ack_a,
  output logic signed [DATA_W-1:0] rdata_a,
  input  logic                     req_b,
  input  logic                     we_b,
  input  logic [ADDR_W-1:0]        addr_b,
  input  logic signed [DATA_W-1:0] wdata_b,
  output logic                     ack_b,
  output logic signed [DATA_W-1:0] rdata_b,
  input  logic                     clr_req,
  output logic                     clr_done,
  output logic                     mem_clr,
  output logic                     mem_rw,
  output logic [ADDR_W-1:0]        mem_address,
  output logic signed [DATA_W-1:0] mem_data_in,
  input  logic signed [DATA_W-1:0] mem_data_out,
  output logic                     busy
`ifdef MEM_ARB_ADDR_CHECK_EN
  ,
  output logic                     err_a,
  output logic                     err_b
`endif
);

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, CAPTURE} state_t;

  state_t                     state;
  logic                       last_b;   // last tie was won by port B
  logic                       sel_b;    // port owning the operation in flight
  logic                       elig_a, elig_b, elig_clr, grant_b, g_we, addr_bad;
  logic [ADDR_W-1:0]          g_addr;
  logic signed [DATA_W-1:0]   g_wdata;

  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("mem_arbiter: DEPTH must lie in 1..2**ADDR_W");
  end

  // A request seen in its own ack cycle is the one just completed.
  always_comb begin
    elig_a   = req_a & ~ack_a;
    elig_b   = req_b & ~ack_b;
    elig_clr = clr_req & ~clr_done;
    grant_b  = elig_b & (~elig_a | ~last_b);
    g_we     = grant_b ? we_b    : we_a;
    g_addr   = grant_b ? addr_b  : addr_a;
    g_wdata  = grant_b ? wdata_b : wdata_a;
  end

`ifdef MEM_ARB_ADDR_CHECK_EN
  assign addr_bad = ({1'b0, g_addr} >= (ADDR_W+1)'(DEPTH));
`else
  assign addr_bad = 1'b0;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      last_b      <= 1'b1;
      sel_b       <= 1'b0;
      ack_a       <= 1'b0;
      ack_b       <= 1'b0;
      rdata_a     <= '0;
      rdata_b     <= '0;
      clr_done    <= 1'b0;
      mem_clr     <= 1'b0;
      mem_rw      <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
`ifdef MEM_ARB_ADDR_CHECK_EN
      err_a       <= 1'b0;
      err_b       <= 1'b0;
`endif
    end else begin
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      clr_done <= 1'b0;
`ifdef MEM_ARB_ADDR_CHECK_EN
      err_a    <= 1'b0;
      err_b    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (elig_clr) begin
            mem_clr <= 1'b1;
            state   <= CLEAR;
          end else if (elig_a | elig_b) begin
            if (elig_a & elig_b) last_b <= grant_b;
            sel_b <= grant_b;
            if (addr_bad) begin
              // Rejected address: acknowledge at once, memory untouched.
              if (grant_b) ack_b <= 1'b1;
              else         ack_a <= 1'b1;
`ifdef MEM_ARB_ADDR_CHECK_EN
              err_a <= ~grant_b;
              err_b <= grant_b;
`endif
            end else begin
              mem_rw      <= g_we;
              mem_address <= g_addr;
              mem_data_in <= g_wdata;
              state       <= ISSUE;
            end
          end
        end
        CLEAR: begin
          mem_clr  <= 1'b0;
          clr_done <= 1'b1;
          state    <= IDLE;
        end
        ISSUE: begin
          if (mem_rw) begin
            mem_rw <= 1'b0;
            if (sel_b) ack_b <= 1'b1;
            else       ack_a <= 1'b1;
            state  <= IDLE;
          end else begin
            state <= CAPTURE;
          end
        end
        CAPTURE: begin
          if (sel_b) begin
            rdata_b <= mem_data_out;
            ack_b   <= 1'b1;
          end else begin
            rdata_a <= mem_data_out;
            ack_a   <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level schedule model.
module tb_mem_arbiter;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 8;
  localparam int N      = 4096;
`ifdef MEM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0, clr_n = 1'b0;
  logic req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0, clr_req = 1'b0;
  logic [ADDR_W-1:0] addr_a = '0, addr_b = '0;
  logic [DATA_W-1:0] wdata_a = '0, wdata_b = '0;
  logic ack_a, ack_b, clr_done, mem_clr, mem_rw, busy;
  logic [DATA_W-1:0] rdata_a, rdata_b, mem_data_in, mem_data_out;
  logic [ADDR_W-1:0] mem_address;
`ifdef MEM_ARB_ADDR_CHECK_EN
  logic err_a, err_b;
`endif

  mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .clr_n(clr_n),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .ack_a(ack_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_b(ack_b), .rdata_b(rdata_b),
    .clr_req(clr_req), .clr_done(clr_done), .mem_clr(mem_clr),
    .mem_rw(mem_rw), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy)
`ifdef MEM_ARB_ADDR_CHECK_EN
    , .err_a(err_a), .err_b(err_b)
`endif
  );

  always #5 clk = ~clk;

  // Scratch memory covering the full address space, one-cycle read latency.
  logic [DATA_W-1:0] tb_mem [16];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= '0;
    end else if (mem_rw) begin
      tb_mem[mem_address] <= mem_data_in;
    end else begin
      mem_data_out <= tb_mem[mem_address];
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: per-cycle schedule of expected outputs
  typedef struct packed {
    bit busy, rw, clr, done, acka, ackb, erra, errb, av, rda, rdb;
    bit [ADDR_W-1:0] addr;
    bit [DATA_W-1:0] din, rd;
  } slot_t;

  slot_t           ex [N];
  bit [DATA_W-1:0] ref_mem [16];
  bit [DATA_W-1:0] exp_rda, exp_rdb;
  bit              last_b_m = 1'b1;
  int              cyc = 0, free_at = 0, p_cyc = -1;
  bit              p_clr;
  bit [ADDR_W-1:0] p_addr;
  bit [DATA_W-1:0] p_data;

  task automatic model_sample(input int k);
    bit ea, eb, ec, gb, we;
    bit [ADDR_W-1:0] ad;
    bit [DATA_W-1:0] d;
    ec = clr_req && !ex[k-1].done;
    ea = req_a && !ex[k-1].acka;
    eb = req_b && !ex[k-1].ackb;
    if (ec) begin
      ex[k].clr = 1; ex[k].busy = 1; ex[k+1].done = 1;
      p_cyc = k + 1; p_clr = 1; free_at = k + 2;
    end else if (ea || eb) begin
      if (ea && eb) begin gb = !last_b_m; last_b_m = gb; end
      else gb = eb;
      we = gb ? we_b : we_a;
      ad = gb ? addr_b : addr_a;
      d  = gb ? wdata_b : wdata_a;
      if (CHK && int'(ad) >= DEPTH) begin
        if (gb) begin ex[k].ackb = 1; ex[k].errb = 1; end
        else    begin ex[k].acka = 1; ex[k].erra = 1; end
        free_at = k + 1;
      end else if (we) begin
        ex[k].busy = 1; ex[k].rw = 1; ex[k].av = 1; ex[k].addr = ad; ex[k].din = d;
        p_cyc = k + 1; p_clr = 0; p_addr = ad; p_data = d;
        if (gb) ex[k+1].ackb = 1; else ex[k+1].acka = 1;
        free_at = k + 2;
      end else begin
        for (int j = 0; j < 2; j++) begin
          ex[k+j].busy = 1; ex[k+j].av = 1; ex[k+j].addr = ad;
        end
        ex[k+2].rd = ref_mem[ad];
        if (gb) begin ex[k+2].ackb = 1; ex[k+2].rdb = 1; end
        else    begin ex[k+2].acka = 1; ex[k+2].rda = 1; end
        free_at = k + 3;
      end
    end
  endtask

  always @(posedge clk) begin
    slot_t s;
    cyc = cyc + 1;
    if (!clr_n) begin
      for (int j = 0; j < 4; j++) ex[cyc+j] = '0;
      p_cyc = -1; last_b_m = 1; free_at = cyc + 1; exp_rda = '0; exp_rdb = '0;
    end else begin
      if (p_cyc == cyc) begin
        if (p_clr) for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        else ref_mem[p_addr] = p_data;
        p_cyc = -1;
      end
      if (cyc >= free_at) model_sample(cyc);
      if (ex[cyc].rda) exp_rda = ex[cyc].rd;
      if (ex[cyc].rdb) exp_rdb = ex[cyc].rd;
    end
    s = ex[cyc];
    #1;
    chk("busy", 64'(busy), 64'(s.busy));
    chk("mem_rw", 64'(mem_rw), 64'(s.rw));
    chk("mem_clr", 64'(mem_clr), 64'(s.clr));
    chk("clr_done", 64'(clr_done), 64'(s.done));
    chk("ack_a", 64'(ack_a), 64'(s.acka));
    chk("ack_b", 64'(ack_b), 64'(s.ackb));
    chk("rdata_a", 64'(rdata_a), 64'(exp_rda));
    chk("rdata_b", 64'(rdata_b), 64'(exp_rdb));
    if (s.av) chk("mem_address", 64'(mem_address), 64'(s.addr));
    if (s.rw) chk("mem_data_in", 64'(mem_data_in), 64'(s.din));
`ifdef MEM_ARB_ADDR_CHECK_EN
    chk("err_a", 64'(err_a), 64'(s.erra));
    chk("err_b", 64'(err_b), 64'(s.errb));
`endif
  end

  // ---------------- directed helpers
  task automatic op(input bit pb, input bit we, input logic [ADDR_W-1:0] ad,
                    input logic [DATA_W-1:0] d, output int lat, output logic [DATA_W-1:0] rd);
    @(negedge clk);
    if (pb) begin req_b = 1; we_b = we; addr_b = ad; wdata_b = d; end
    else    begin req_a = 1; we_a = we; addr_a = ad; wdata_a = d; end
    lat = 0; rd = '0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #2;
      if ((pb ? ack_b : ack_a) === 1'b1) begin
        lat = i; rd = pb ? rdata_b : rdata_a; break;
      end
    end
    @(negedge clk);
    if (pb) req_b = 0; else req_a = 0;
    chk("op_ack_seen", 64'(lat != 0), 64'(1));
  endtask

  task automatic tie(input bit wea, input logic [ADDR_W-1:0] ada, input logic [DATA_W-1:0] da,
                     input bit web, input logic [ADDR_W-1:0] adb, input logic [DATA_W-1:0] db,
                     output int first, output logic [DATA_W-1:0] rdb);
    bit got_a = 0, got_b = 0;
    @(negedge clk);
    req_a = 1; we_a = wea; addr_a = ada; wdata_a = da;
    req_b = 1; we_b = web; addr_b = adb; wdata_b = db;
    first = -1; rdb = '0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #2;
      if (ack_a === 1'b1 && !got_a) begin got_a = 1; if (first < 0) first = 0; end
      if (ack_b === 1'b1 && !got_b) begin got_b = 1; rdb = rdata_b; if (first < 0) first = 1; end
      @(negedge clk);
      if (got_a) req_a = 0;
      if (got_b) req_b = 0;
      if (got_a && got_b) break;
    end
    req_a = 0; req_b = 0;
    chk("tie_both_served", 64'(got_a && got_b), 64'(1));
  endtask

  task automatic do_clear();
    bit got = 0;
    @(negedge clk); clr_req = 1;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #2;
      if (clr_done === 1'b1) begin got = 1; break; end
    end
    @(negedge clk); clr_req = 0;
    chk("clear_done_seen", 64'(got), 64'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, first, nclr;
    bit saw, got;
    logic [DATA_W-1:0] rd;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, mem_rw, mem_clr, ack_a, ack_b, clr_done,
                              mem_address, mem_data_in, rdata_a, rdata_b}), 64'(0));
    clr_n = 1;
    do_clear();

    // Write then read back on port A.
    op(0, 1, 4'd3, 8'h5A, lat, rd);
    chk("wr_ack_latency", 64'(lat), 64'(2));
    op(0, 0, 4'd3, 8'h00, lat, rd);
    chk("rd_ack_latency", 64'(lat), 64'(3));
    chk("rd_data_5a", 64'(rd), 64'(8'h5A));

    // Round-robin on simultaneous requests.
    tie(1, 4'd1, 8'h11, 0, 4'd0, 8'h00, first, rd);
    chk("tie1_a_first", 64'(first), 64'(0));
    chk("tie1_b_rdata", 64'(rd), 64'(8'h00));
    tie(0, 4'd3, 8'h00, 1, 4'd2, 8'h22, first, rd);
    chk("tie2_b_first", 64'(first), 64'(1));
    tie(1, 4'd4, 8'h44, 0, 4'd1, 8'h00, first, rd);
    chk("tie3_a_first", 64'(first), 64'(0));
    chk("tie3_b_rdata", 64'(rd), 64'(8'h11));

    // Clear beats a simultaneous read.
    @(negedge clk);
    clr_req = 1; req_a = 1; we_a = 0; addr_a = 4'd3;
    nclr = 0; saw = 0; got = 0; rd = '1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #2;
      if (mem_clr === 1'b1) nclr++;
      if (clr_done === 1'b1) saw = 1;
      if (ack_a === 1'b1) begin got = 1; rd = rdata_a; end
      @(negedge clk);
      if (saw) clr_req = 0;
      if (got) begin req_a = 0; break; end
    end
    clr_req = 0; req_a = 0;
    chk("clr_pulse_cycles", 64'(nclr), 64'(1));
    chk("clr_done_pulse", 64'(saw), 64'(1));
    chk("clr_then_a_acked", 64'(got), 64'(1));
    chk("rd_after_clear", 64'(rd), 64'(0));

    // Signed extreme passes bit-exact across ports.
    op(1, 1, 4'd7, 8'h80, lat, rd);
    op(0, 0, 4'd7, 8'h00, lat, rd);
    chk("rd_minus128", 64'(rd), 64'(8'h80));
    chk("rdata_b_held", 64'(rdata_b), 64'(8'h11));

    // Reset while a B write is being issued.
    @(negedge clk);
    req_b = 1; we_b = 1; addr_b = 4'd5; wdata_b = 8'h33;
    @(posedge clk); #1;
    chk("issue_busy", 64'(busy), 64'(1));
    #1 clr_n = 0;
    #1 chk("async_reset_outputs", 64'({busy, mem_rw, mem_clr, ack_a, ack_b, clr_done,
                                       mem_address, mem_data_in, rdata_a, rdata_b}), 64'(0));
    @(negedge clk); req_b = 0;
    @(posedge clk); #2;
    chk("no_ack_b_in_reset", 64'(ack_b), 64'(0));
    @(negedge clk); clr_n = 1;
    op(0, 0, 4'd5, 8'h00, lat, rd);
    chk("post_reset_rd_latency", 64'(lat), 64'(3));
    chk("aborted_write_absent", 64'(rd), 64'(0));

`ifdef MEM_ARB_ADDR_CHECK_EN
    @(negedge clk);
    req_a = 1; we_a = 1; addr_a = 4'd9; wdata_a = 8'h77;
    @(posedge clk); #2;
    chk("oob_ack_err_rw_busy", 64'({ack_a, err_a, mem_rw, busy}), 64'(4'b1100));
    @(negedge clk); req_a = 0;
    repeat (2) @(negedge clk);
    chk("oob_mem9_untouched", 64'(tb_mem[9]), 64'(0));
`endif

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (req_a && ack_a) begin
        if ($urandom_range(0, 1) == 0) req_a = 0;
        else begin
          we_a = 1'($urandom); wdata_a = 8'($urandom);
          addr_a = 4'($urandom_range(0, CHK ? 15 : DEPTH - 1));
        end
      end else if (!req_a && $urandom_range(0, 2) == 0) begin
        req_a = 1; we_a = 1'($urandom); wdata_a = 8'($urandom);
        addr_a = 4'($urandom_range(0, CHK ? 15 : DEPTH - 1));
      end
      if (req_b && ack_b) begin
        if ($urandom_range(0, 1) == 0) req_b = 0;
        else begin
          we_b = 1'($urandom); wdata_b = 8'($urandom);
          addr_b = 4'($urandom_range(0, CHK ? 15 : DEPTH - 1));
        end
      end else if (!req_b && $urandom_range(0, 2) == 0) begin
        req_b = 1; we_b = 1'($urandom); wdata_b = 8'($urandom);
        addr_b = 4'($urandom_range(0, CHK ? 15 : DEPTH - 1));
      end
      if (clr_req && clr_done) clr_req = 0;
      else if (!clr_req && $urandom_range(0, 39) == 0) clr_req = 1;
    end
    @(negedge clk);
    req_a = 0; req_b = 0; clr_req = 0;
    repeat (6) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port round-robin arbiter and sequencer in front of the 8-word x 8-bit signed scratch memory.
- Ports A (instruction side) and B (data side) share the memory's single rw/address/data_in/data_out path.
- Handles the memory's one-cycle registered read latency and sequences a whole-memory clear on request.
- All memory control lines are driven from registers.

Parameters:
DATA_W, 8, data word width
ADDR_W, 4, address width (matches memory address port)
DEPTH, 8, number of valid words; addresses 0..DEPTH-1

Ports:
clk  input  1  clock, rising edge
clr_n  input  1  asynchronous active-low reset
req_a  input  1  port A request; held until ack_a
we_a  input  1  port A: 1=write, 0=read
addr_a  input  ADDR_W  port A address
wdata_a  input  DATA_W  port A write data (signed)
ack_a  output  1  port A one-cycle completion pulse
rdata_a  output  DATA_W  port A read data, valid while ack_a=1 for reads, held afterwards
req_b, we_b, addr_b, wdata_b, ack_b, rdata_b  same as port A, for port B
clr_req  input  1  request a memory clear (level, held until clr_done)
clr_done  output  1  one-cycle pulse when the clear is issued
mem_clr  output  1  to memory clr
mem_rw  output  1  to memory rw (1=write)
mem_address  output  ADDR_W  to memory address
mem_data_in  output  DATA_W  to memory data_in
mem_data_out  input  DATA_W  from memory data_out
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (clr_n=0, async): state=IDLE, all outputs 0, last_grant=B so A wins the first tie. Memory contents are untouched by reset.
- Reset mid-operation: the operation is abandoned, no ack is issued, and mem_rw drops to 0 immediately.
- States: IDLE, CLEAR, ISSUE, CAPTURE.
- IDLE: mem_rw=0, mem_clr=0. Eligible requests are sampled at the clock edge, in this priority order:
  - clr_req=1 -> mem_clr<=1, go to CLEAR. Clear has priority over both ports.
  - Otherwise, among eligible req_a/req_b: a single requester is granted. If both request, grant the port not in last_grant, then update last_grant.
  - On grant, latch we/addr/wdata into mem_rw/mem_address/mem_data_in and go to ISSUE.
- Eligibility: a port's req is ignored in any cycle where its own ack is high, so a requester may drop req on seeing ack. The clr_req held through the clr_done cycle is likewise ignored.
- CLEAR: the memory clears on this edge. Next state is IDLE, with mem_clr<=0 and clr_done<=1 for one cycle.
- ISSUE: the memory performs the access on this edge.
  - Write: next state IDLE, mem_rw<=0, ack_x<=1. Ack is visible 2 cycles after the sampling edge.
  - Read: next state CAPTURE.
- CAPTURE: rdata_x<=mem_data_out, ack_x<=1, next state IDLE. Read ack and rdata are visible 3 cycles after the sampling edge.
- ack_a and ack_b are never both high. rdata_x changes only on port x's read completion.
- Request changes after the grant are ignored; the latched operation completes.
- Data is passed bit-exact (signed, no extension or truncation). mem_address is driven with the full ADDR_W.
- Back-to-back throughput: one write per 2 cycles, one read per 3 cycles per granted operation.

Optional Feature:
MEM_ARB_ADDR_CHECK_EN
- Defined: in IDLE, a granted request with addr >= DEPTH performs no memory access and stays in IDLE. The port receives ack_x=1 plus a new output err_x=1 for the same single cycle, and rdata_x is unchanged. err_a/err_b reset to 0. last_grant is still updated.
- Undefined: there are no err ports, and the address is passed through unchecked.

Test Plan:
- Write A addr=3 wdata=0x5A, then read A addr=3 -> ack_a 2 cycles after the write sample; on the read, ack_a 3 cycles after sample with rdata_a=0x5A.
- After reset, req_a and req_b asserted together (B read addr 0) -> A served first, then B. Both re-requested together -> B served first. Grants alternate.
- clr_req=1 and req_a (read addr 3) in the same cycle -> mem_clr high exactly 1 cycle, clr_done pulse, then A served with rdata_a=0x00.
- B writes -128 (0x80) to addr 7, then A reads addr 7 -> rdata_a=0x80; rdata_b unchanged.
- clr_n pulled low during ISSUE of a B write -> all outputs 0 asynchronously, no ack_b, busy=0. The next request is served normally.
- MEM_ARB_ADDR_CHECK_EN defined: A write addr=9 -> ack_a=err_a=1 for 1 cycle, mem_rw stays 0 throughout, and the memory is unchanged.
